// File: rtl/sevenseg_decoder.sv
// sevenseg_decoder
//   Hex-to-seven-segment decoder for one display digit. Produces glyphs 0-9
//   and A-F on a combinational output for immediate use. A registered copy
//   is kept for pad-driving display logic.
//
//   Parameters
//     ACTIVE_LOW  1: both outputs inverted (common-anode); 0: lit segment = 1
//
//   Ports
//     clk       in   1  system clock; seg_q updates on rising edge
//     reset     in   1  asynchronous, active-high reset of seg_q
//     data      in   4  hex digit 0x0-0xF
//     blank     in   1  1: all segments unlit regardless of data
//     segments  out  7  combinational pattern {a,b,c,d,e,f,g}
//     seg_q     out  7  segments registered on rising clk, same bit order
module sevenseg_decoder #(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] data,
  input  logic       blank,
  output logic [6:0] segments,
  output logic [6:0] seg_q
);

  // Output polarity mask: XOR the lit=1 pattern with this to get pad polarity.
  localparam logic [6:0] POL   = {7{ACTIVE_LOW}};
  localparam logic [6:0] UNLIT = 7'b0000000 ^ POL;

  logic [6:0] lit;

  // blank is folded into the case selector so that blank=1 and any X/Z on
  // blank or data both miss every explicit item and fall to the unlit default.
  // This keeps X from reaching either output.
  always_comb begin
    lit = 7'b0000000;
    case ({blank, data})
      5'b0_0000: lit = 7'b1111110;
      5'b0_0001: lit = 7'b0110000;
      5'b0_0010: lit = 7'b1101101;
      5'b0_0011: lit = 7'b1111001;
      5'b0_0100: lit = 7'b0110011;
      5'b0_0101: lit = 7'b1011011;
      5'b0_0110: lit = 7'b1011111;
      5'b0_0111: lit = 7'b1110000;
      5'b0_1000: lit = 7'b1111111;
      5'b0_1001: lit = 7'b1110011;
      5'b0_1010: lit = 7'b1110111;
      5'b0_1011: lit = 7'b0011111;
      5'b0_1100: lit = 7'b1001110;
      5'b0_1101: lit = 7'b0111101;
      5'b0_1110: lit = 7'b1001111;
      5'b0_1111: lit = 7'b1000111;
      default:   lit = 7'b0000000;
    endcase
  end

  assign segments = lit ^ POL;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) seg_q <= UNLIT;
    else       seg_q <= segments;
  end

endmodule

// File: tb/tb_sevenseg_decoder.sv
module tb_sevenseg_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] data;
  logic       blank;
  logic [6:0] seg0, q0, seg1, q1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sevenseg_decoder #(.ACTIVE_LOW(1'b0)) u0 (
    .clk(clk), .reset(reset), .data(data), .blank(blank),
    .segments(seg0), .seg_q(q0)
  );

  sevenseg_decoder #(.ACTIVE_LOW(1'b1)) u1 (
    .clk(clk), .reset(reset), .data(data), .blank(blank),
    .segments(seg1), .seg_q(q1)
  );

  // Glyph table {a,b,c,d,e,f,g}, lit = 1
  logic [6:0] glyph [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1110011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  function automatic logic [6:0] model(logic [3:0] d, logic b, bit al);
    logic [6:0] l;
    if (b !== 1'b0 || $isunknown(d)) l = 7'b0000000;
    else                             l = glyph[int'(d)];
    return al ? ~l : l;
  endfunction

  task automatic chk(string tag, logic [6:0] obs, logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_seg(string tag);
    chk({tag, " seg"},    seg0, model(data, blank, 1'b0));
    chk({tag, " seg_al"}, seg1, model(data, blank, 1'b1));
  endtask

  task automatic chk_q(string tag);
    chk({tag, " q"},    q0, model(data, blank, 1'b0));
    chk({tag, " q_al"}, q1, model(data, blank, 1'b1));
  endtask

  initial begin
    reset = 1'b1;
    data  = 4'h0;
    blank = 1'b0;
    #1;
    chk("reset q",    q0, 7'b0000000);
    chk("reset q_al", q1, 7'b1111111);
    chk("reset seg",  seg0, 7'b1111110);
    chk("reset seg_al", seg1, 7'b0000001);

    // seg_q holds unlit across an edge while reset is high
    @(posedge clk); #1;
    chk("reset hold q",    q0, 7'b0000000);
    chk("reset hold q_al", q1, 7'b1111111);

    @(negedge clk);
    reset = 1'b0;

    // Full sweep
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      data = 4'(i);
      #1 chk_seg($sformatf("sweep %0h", i));
      @(posedge clk); #1 chk_q($sformatf("sweep %0h", i));
    end

    // Spot checks against literal patterns
    @(negedge clk); data = 4'h5; #1 chk("lit 5", seg0, 7'b1011011);
    @(negedge clk); data = 4'h9; #1 chk("lit 9", seg0, 7'b1110011);
    @(negedge clk); data = 4'hF; #1 chk("lit F", seg0, 7'b1000111);

    // Blank overrides data, release takes effect at once
    @(negedge clk);
    data = 4'h8; blank = 1'b1;
    #1 chk("blank", seg0, 7'b0000000);
    chk("blank al", seg1, 7'b1111111);
    blank = 1'b0;
    #1 chk("unblank", seg0, 7'b1111111);
    @(posedge clk); #1 chk("q 8", q0, 7'b1111111);

    // Async reset mid-cycle clears seg_q before the next edge
    @(negedge clk);
    #2 reset = 1'b1;
    #1 chk("async rst q",    q0, 7'b0000000);
    chk("async rst q_al", q1, 7'b1111111);
    chk("seg ignores rst", seg0, 7'b1111111);
    @(posedge clk); #1 chk("rst held q", q0, 7'b0000000);
    @(negedge clk);
    reset = 1'b0; data = 4'h3;
    @(posedge clk); #1 chk("post rst q", q0, 7'b1111001);
    chk("post rst q_al", q1, 7'b0000110);

    // Data change between edges: comb follows, register waits
    @(negedge clk); data = 4'h2;
    @(posedge clk); #1 chk("q 2", q0, 7'b1101101);
    #2 data = 4'h7;
    #1 chk("seg 7 early", seg0, 7'b1110000);
    chk("q still 2", q0, 7'b1101101);
    @(posedge clk); #1 chk("q 7", q0, 7'b1110000);

    // ACTIVE_LOW digit 0
    @(negedge clk); data = 4'h0;
    #1 chk("al 0", seg1, 7'b0000001);

    // Unknown data must decode unlit and never show X
    @(negedge clk); data = 4'bxxxx;
    #1 chk_seg("xdata");
    checks++;
    assert (!$isunknown({seg0, seg1})) else begin
      failures++;
      $error("FAIL xdata known: got %b %b expected no X", seg0, seg1);
    end
    @(posedge clk); #1 chk_q("xdata");

    // Randomized against the model
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      data  = 4'($urandom);
      blank = ($urandom_range(0, 3) == 0);
      #1 chk_seg("rand");
      @(posedge clk); #1 chk_q("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
